// File: rtl/morse_pkg.sv
// morse_pkg: shared types and the Morse lookup for morse_stream_decoder.
//   state_t       : decoder FSM states (IDLE / ACCUM / SPACE)
//   ASCII_*       : fixed output bytes
//   morse_lookup  : {len, code} -> ASCII. The first symbol is the MSB of the
//                   len-bit code (dot=0, dash=1). Digits 0-9 are decoded only
//                   when MORSE_DIGITS_EN is defined.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SPACE = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    // Code bits above len are always zero, so the key can be matched exactly.
    function automatic logic [7:0] morse_lookup(input logic [3:0]  len,
                                                input logic [6:0]  code,
                                                input int unsigned max_len);
        logic [7:0] ch;
        ch = ASCII_UNKNOWN;
        if (32'(len) <= max_len) begin
            case ({len, code})
                {4'd2, 7'b01}:    ch = 8'h41; // A
                {4'd4, 7'b1000}:  ch = 8'h42; // B
                {4'd4, 7'b1010}:  ch = 8'h43; // C
                {4'd3, 7'b100}:   ch = 8'h44; // D
                {4'd1, 7'b0}:     ch = 8'h45; // E
                {4'd4, 7'b0010}:  ch = 8'h46; // F
                {4'd3, 7'b110}:   ch = 8'h47; // G
                {4'd4, 7'b0000}:  ch = 8'h48; // H
                {4'd2, 7'b00}:    ch = 8'h49; // I
                {4'd4, 7'b0111}:  ch = 8'h4A; // J
                {4'd3, 7'b101}:   ch = 8'h4B; // K
                {4'd4, 7'b0100}:  ch = 8'h4C; // L
                {4'd2, 7'b11}:    ch = 8'h4D; // M
                {4'd2, 7'b10}:    ch = 8'h4E; // N
                {4'd3, 7'b111}:   ch = 8'h4F; // O
                {4'd4, 7'b0110}:  ch = 8'h50; // P
                {4'd4, 7'b1101}:  ch = 8'h51; // Q
                {4'd3, 7'b010}:   ch = 8'h52; // R
                {4'd3, 7'b000}:   ch = 8'h53; // S
                {4'd1, 7'b1}:     ch = 8'h54; // T
                {4'd3, 7'b001}:   ch = 8'h55; // U
                {4'd4, 7'b0001}:  ch = 8'h56; // V
                {4'd3, 7'b011}:   ch = 8'h57; // W
                {4'd4, 7'b1001}:  ch = 8'h58; // X
                {4'd4, 7'b1011}:  ch = 8'h59; // Y
                {4'd4, 7'b1100}:  ch = 8'h5A; // Z
`ifdef MORSE_DIGITS_EN
                {4'd5, 7'b11111}: ch = 8'h30;
                {4'd5, 7'b01111}: ch = 8'h31;
                {4'd5, 7'b00111}: ch = 8'h32;
                {4'd5, 7'b00011}: ch = 8'h33;
                {4'd5, 7'b00001}: ch = 8'h34;
                {4'd5, 7'b00000}: ch = 8'h35;
                {4'd5, 7'b10000}: ch = 8'h36;
                {4'd5, 7'b11000}: ch = 8'h37;
                {4'd5, 7'b11100}: ch = 8'h38;
                {4'd5, 7'b11110}: ch = 8'h39;
`endif
                default:          ch = ASCII_UNKNOWN;
            endcase
        end
        return ch;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// morse_fifo: synchronous show-ahead FIFO.
//   push/push_data : write request (ignored when full unless popping too)
//   pop            : read request (ignored when empty)
//   pop_data       : head entry, 0 when empty
//   full/empty/count : occupancy
module morse_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             rd_en;
    logic             wr_en;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (count == PW'(FIFO_DEPTH));
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: Morse key inputs -> ASCII stream with valid/ready FIFO.
//   dot_inp/dash_inp/char_space_inp/word_space_inp : key levels, edge-detected
//   out_data/out_valid/out_ready : show-ahead output handshake
//   fifo_count : occupied FIFO entries
//   ovf        : sticky, a character was dropped on a full FIFO
//   sym_len    : symbols collected for the current character
// Build option: MORSE_DIGITS_EN adds digit decoding (needs MAX_LEN >= 5).
module morse_stream_decoder
    import morse_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 5,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dot_inp,
    input  logic                        dash_inp,
    input  logic                        char_space_inp,
    input  logic                        word_space_inp,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        ovf,
    output logic [2:0]                  sym_len
);
    localparam logic [3:0] LEN_SAT = 4'(MAX_LEN + 1);

`ifdef MORSE_DIGITS_EN
    if (MAX_LEN < 5) begin : g_digit_len_check
        $error("MORSE_DIGITS_EN requires MAX_LEN >= 5");
    end
`endif

    state_t               state;
    state_t               state_n;
    logic [MAX_LEN-1:0]   code;
    logic [MAX_LEN-1:0]   code_n;
    logic [3:0]           len;
    logic [3:0]           len_n;
    logic [7:0]           last_byte;
    logic [3:0]           keys;
    logic [3:0]           key_prev;
    logic [3:0]           key_ev;
    logic                 ev_word;
    logic                 ev_char;
    logic                 ev_sym;
    logic                 push_c;
    logic [7:0]           push_data_c;
    logic                 pop_c;
    logic                 full;
    logic                 empty;
    logic [7:0]           lookup_c;

    // Registered rising-edge events, bit order {word, char, dash, dot}.
    assign keys = {word_space_inp, char_space_inp, dash_inp, dot_inp};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev <= '0;
            key_ev   <= '0;
        end else begin
            key_prev <= keys;
            key_ev   <= keys & ~key_prev;
        end
    end

    // Priority word > char > symbol; dash beats dot through the shifted-in bit.
    assign ev_word  = key_ev[3];
    assign ev_char  = key_ev[2] & ~key_ev[3];
    assign ev_sym   = (key_ev[1] | key_ev[0]) & ~key_ev[3] & ~key_ev[2];
    assign lookup_c = morse_lookup(len, 7'(code), MAX_LEN);

    // State and accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            code  <= '0;
            len   <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
            len   <= len_n;
        end
    end

    // Next state, accumulator update and FIFO push request
    always_comb begin
        state_n     = state;
        code_n      = code;
        len_n       = len;
        push_c      = 1'b0;
        push_data_c = ASCII_SPACE;
        case (state)
            IDLE: begin
                if (ev_word) begin
                    push_c = (last_byte != ASCII_SPACE);
                end else if (ev_sym) begin
                    code_n  = {code[MAX_LEN-2:0], key_ev[1]};
                    len_n   = 4'd1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (ev_word || ev_char) begin
                    push_c      = 1'b1;
                    push_data_c = lookup_c;
                    code_n      = '0;
                    len_n       = '0;
                    state_n     = ev_word ? SPACE : IDLE;
                end else if (ev_sym) begin
                    code_n = {code[MAX_LEN-2:0], key_ev[1]};
                    len_n  = (len == LEN_SAT) ? len : len + 4'd1;
                end
            end
            SPACE: begin
                push_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Last pushed byte suppresses repeated word spaces; ovf is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_byte <= ASCII_SPACE;
            ovf       <= 1'b0;
        end else begin
            if (push_c) last_byte <= push_data_c;
            if (push_c && full && !pop_c) ovf <= 1'b1;
        end
    end

    assign pop_c     = out_valid & out_ready;
    assign out_valid = ~empty;
    assign sym_len   = len[3] ? 3'd7 : len[2:0];

    morse_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Scoreboard bench for morse_stream_decoder: stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted output.
module tb_morse_stream_decoder;
    localparam int unsigned MAX_LEN    = 5;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dot_inp = 1'b0;
    logic          dash_inp = 1'b0;
    logic          char_space_inp = 1'b0;
    logic          word_space_inp = 1'b0;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic [2:0]    sym_len;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morse_stream_decoder #(
        .MAX_LEN    (MAX_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dot_inp        (dot_inp),
        .dash_inp       (dash_inp),
        .char_space_inp (char_space_inp),
        .word_space_inp (word_space_inp),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .ovf            (ovf),
        .sym_len        (sym_len)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
            end else begin
                check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // k: 0 dot, 1 dash, 2 char_space, 3 word_space; held 3 cycles, 3 low.
    task automatic set_key(input int k, input logic v);
        case (k)
            0: dot_inp = v;
            1: dash_inp = v;
            2: char_space_inp = v;
            default: word_space_inp = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b1);
        cycles(3);
        set_key(k, 1'b0);
        cycles(3);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            cycles(1);
            n++;
        end
        check({name, "_left"}, int'(exp_q.size()), 0);
        check({name, "_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_len", int'(sym_len), 0);
        rst = 1'b1;
        cycles(2);

        // 'A' with latency check on the char_space rise
        press(0);
        check("a_len1", int'(sym_len), 1);
        press(1);
        check("a_len2", int'(sym_len), 2);
        exp_q.push_back(8'h41);
        char_space_inp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("a_valid_early", int'(out_valid), 0);
        @(negedge clk);
        check("a_valid_k2", int'(out_valid), 1);
        @(posedge clk);
        #1;
        char_space_inp = 1'b0;
        cycles(3);
        check("a_len0", int'(sym_len), 0);
        drain("a");

        // 'S' then word space; a second word space adds nothing
        press(0); press(0); press(0);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h20);
        press(3);
        drain("s");
        press(3);
        cycles(4);
        check("no_double_space", int'(out_valid), 0);

        // Six dashes: too long
        for (int i = 0; i < 5; i++) press(1);
        check("long_len5", int'(sym_len), 5);
        press(1);
        check("long_len_sat", int'(sym_len), 6);
        exp_q.push_back(8'h3F);
        press(2);
        drain("long");

        // Overflow: nine 'E' into an 8-deep stalled FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            press(0);
            press(2);
            if (i < 8) exp_q.push_back(8'h45);
        end
        check("ovf_count", int'(fifo_count), 8);
        check("ovf_flag", int'(ovf), 1);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", int'(ovf), 1);

        // Five dashes: digit 0 or unknown
        for (int i = 0; i < 5; i++) press(1);
`ifdef MORSE_DIGITS_EN
        exp_q.push_back(8'h30);
`else
        exp_q.push_back(8'h3F);
`endif
        press(2);
        drain("digit0");

        // Dot and dash together: dash only -> 'T'
        dot_inp = 1'b1;
        dash_inp = 1'b1;
        cycles(3);
        dot_inp = 1'b0;
        dash_inp = 1'b0;
        cycles(3);
        check("simul_len", int'(sym_len), 1);
        exp_q.push_back(8'h54);
        press(2);
        drain("simul");

        // Reset in the middle of a character with a stored byte
        out_ready = 1'b0;
        press(0);
        press(2);
        press(0);
        press(1);
        check("pre_rst_count", int'(fifo_count), 1);
        check("pre_rst_len", int'(sym_len), 2);
        rst = 1'b0;
        #2;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_len", int'(sym_len), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_data", int'(out_data), 0);
        cycles(2);
        rst = 1'b1;
        cycles(2);
        out_ready = 1'b1;
        press(2);
        cycles(3);
        check("post_rst_nopush", int'(fifo_count), 0);
        check("post_rst_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
